// File: rtl/energy_gate_pkg.sv
// Shared types and constants for the energy_gate segment detector.
// The optional seg_len output is enabled by defining ENERGY_GATE_SEG_LEN_EN.
package energy_gate_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_WIN_LOG2   = 5;
    localparam int DEF_ON_HOLD    = 4;
    localparam int DEF_OFF_HOLD   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2
    } gate_state_t;

    // Wide enough to hold any count up to the larger of the two hold limits.
    function automatic int hold_width(input int on_hold, input int off_hold);
        int m;
        m = (on_hold > off_hold) ? on_hold : off_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/energy_window_sum.sv
// Sliding-window sum over the last 2^WIN_LOG2 squared samples.
// A circular buffer supplies the sample leaving the window once it is full.
module energy_window_sum
    import energy_gate_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WIN_LOG2   = DEF_WIN_LOG2,
    parameter int SUM_WIDTH  = DATA_WIDTH + WIN_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  energy_valid,
    output logic [SUM_WIDTH-1:0]  energy,
    output logic                  win_full
);

    localparam int N = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_MAX  = (WIN_LOG2 + 1)'(N);
    localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2 + 1)'(N - 1);

    logic [DATA_WIDTH-1:0] mem [N];
    logic [WIN_LOG2-1:0]   wr_ptr;
    logic [WIN_LOG2:0]     fill_cnt;
    logic [DATA_WIDTH-1:0] old;
    logic [SUM_WIDTH-1:0]  sum_next;
    logic                  at_max;
    logic                  fills_now;

    always_comb begin
        at_max    = (fill_cnt == FILL_MAX);
        fills_now = at_max || (fill_cnt == FILL_LAST);
        // Until the window is full nothing has left it yet.
        old       = at_max ? mem[wr_ptr] : '0;
        sum_next  = energy + SUM_WIDTH'(in_data) - SUM_WIDTH'(old);
    end

    // Sample storage is deliberately not reset; fill_cnt masks stale entries.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            energy       <= '0;
            energy_valid <= 1'b0;
            win_full     <= 1'b0;
        end else begin
            energy_valid <= 1'b0;
            if (in_valid) begin
                energy       <= sum_next;
                wr_ptr       <= wr_ptr + 1'b1;
                win_full     <= fills_now;
                energy_valid <= fills_now;
                if (!at_max) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/energy_gate.sv
// Windowed-energy segment detector with on/off hysteresis and hold counts.
// Define ENERGY_GATE_SEG_LEN_EN to add the seg_len output.
module energy_gate
    import energy_gate_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WIN_LOG2   = DEF_WIN_LOG2,
    parameter int SUM_WIDTH  = DATA_WIDTH + WIN_LOG2,
    parameter int ON_HOLD    = DEF_ON_HOLD,
    parameter int OFF_HOLD   = DEF_OFF_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    // in_valid qualifies in_data for exactly one cycle; there is no ready,
    // every valid sample is consumed, one per cycle at most.
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SUM_WIDTH-1:0]  thr_on,
    input  logic [SUM_WIDTH-1:0]  thr_off,
    output logic                  energy_valid,
    output logic [SUM_WIDTH-1:0]  energy,
    output logic                  win_full,
    output logic                  seg_active,
    output logic                  seg_start,
    output logic                  seg_end
`ifdef ENERGY_GATE_SEG_LEN_EN
    ,
    output logic [15:0]           seg_len
`endif
);

    localparam int HOLD_W = hold_width(ON_HOLD, OFF_HOLD);
    localparam logic [HOLD_W-1:0] ON_LIM  = HOLD_W'(ON_HOLD);
    localparam logic [HOLD_W-1:0] OFF_LIM = HOLD_W'(OFF_HOLD);

    gate_state_t       state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              start_next, end_next;

    energy_window_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIN_LOG2   (WIN_LOG2),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .energy_valid (energy_valid),
        .energy       (energy),
        .win_full     (win_full)
    );

    // hold_cnt counts on-hits while ARMING and off-hits while ACTIVE.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        start_next    = 1'b0;
        end_next      = 1'b0;
        if (energy_valid) begin
            case (state)
                IDLE: begin
                    if (energy >= thr_on) begin
                        if (ON_LIM == HOLD_W'(1)) begin
                            state_next    = ACTIVE;
                            start_next    = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            state_next    = ARMING;
                            hold_cnt_next = HOLD_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (energy >= thr_on) begin
                        if (hold_cnt + 1'b1 >= ON_LIM) begin
                            state_next    = ACTIVE;
                            start_next    = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt + 1'b1;
                        end
                    end else begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end
                end
                ACTIVE: begin
                    if (energy < thr_off) begin
                        if (hold_cnt + 1'b1 >= OFF_LIM) begin
                            state_next    = IDLE;
                            end_next      = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            seg_active <= 1'b0;
            seg_start  <= 1'b0;
            seg_end    <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            seg_active <= (state_next == ACTIVE);
            seg_start  <= start_next;
            seg_end    <= end_next;
        end
    end

`ifdef ENERGY_GATE_SEG_LEN_EN
    // Counts energy updates from the opening one; frozen once the segment closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_len <= '0;
        end else if (start_next) begin
            seg_len <= 16'd1;
        end else if (energy_valid && (state == ACTIVE) && (seg_len != 16'hFFFF)) begin
            seg_len <= seg_len + 16'd1;
        end
    end
`endif

endmodule
